load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_START_ADDRESS, default 32'h00000000: byte address of memory word 0.
REQ-002 SHALL have parameter MEM_BYTES, default 65536: size of the addressable data window in bytes.
REQ-003 SHALL have port clk_i  in  1: sole clock; all state on rising edge.
REQ-004 SHALL have port rst_i  in  1: asynchronous, active-low reset.
REQ-005 SHALL have ports req_valid_i in 1 / req_ready_o out 1: request handshake.
REQ-006 SHALL have ports req_we_i in 1 (1 = store), req_size_i in 2 (0 = byte, 1 = half, 2 = word, 3 = reserved), req_unsigned_i in 1 (zero-extend loads).
REQ-007 SHALL have ports req_addr_i in 32 (byte address) and req_wdata_i in 32 (store data, LSB-aligned).
REQ-008 SHALL have ports rsp_valid_o out 1 / rsp_ready_i in 1, rsp_rdata_o out 32, rsp_err_o out 1: response handshake.
REQ-009 SHALL have ports mem_addr_o out 14 (word index), mem_data_o out 32, mem_wr_o out 4 (byte write enables), mem_data_i in 32: memory port with combinational read and synchronous byte-masked write.

Function
REQ-010 SHALL use states IDLE, ACC0, ACC1, RESP; req_ready_o = 1 only in IDLE.
REQ-011 On req_valid_i & req_ready_o, SHALL register all req_* fields and compute off = req_addr_i - DATA_START_ADDRESS.
REQ-012 SHALL flag an error if size = 3 or off + (1 << size) - 1 >= MEM_BYTES. An errored request SHALL go IDLE->RESP with rsp_err_o = 1, rsp_rdata_o = 0, and no memory write.
REQ-013 A non-errored request SHALL go IDLE->ACC0. It SHALL be "split" when off[1:0] + (1 << size) > 4.
REQ-014 In ACC0, SHALL drive mem_addr_o = off[15:2]. A store SHALL assert mem_wr_o bits for the bytes lying in that word, with data shifted left by 8*off[1:0].
REQ-015 In ACC0, SHALL capture mem_data_i into a low-word register. Next state SHALL be ACC1 if split, else RESP.
REQ-016 In ACC1, SHALL drive mem_addr_o = off[15:2] + 1, the remaining low-order byte enables, and the remaining store bytes. SHALL capture mem_data_i into a high-word register, then go to RESP.
REQ-017 Outside ACC0/ACC1, mem_wr_o SHALL be 4'b0000. mem_addr_o and mem_data_o SHALL hold their last values.
REQ-018 Load data SHALL be {high, low} >> 8*off[1:0], truncated to the access size, then sign-extended (req_unsigned_i = 0) or zero-extended. Stores SHALL return rsp_rdata_o = 0.
REQ-019 In RESP, rsp_valid_o = 1 and the outputs SHALL be held stable until rsp_ready_i = 1. RESP->IDLE on that cycle.
REQ-020 Latency from accept edge to first rsp_valid_o: aligned/non-split = 2 cycles, split = 3, error = 1.
REQ-021 No new request SHALL be accepted in the cycle rsp_valid_o & rsp_ready_i occurs; acceptance resumes the next cycle.
REQ-022 req_* inputs SHALL be ignored outside IDLE.

Reset
REQ-023 On rst_i = 0, SHALL go asynchronously to IDLE with req_ready_o = 1, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0, mem_addr_o = 0, mem_data_o = 0, mem_wr_o = 0.
REQ-024 Reset in ACC1 SHALL abort the access; a completed ACC0 write is not rolled back.

Structure
REQ-025 State enum, size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and the byte-enable lookup SHALL live in shared package lsu_pkg.
REQ-026 Load extraction/extension SHALL be a combinational sub-module, lsu_load_align.

Verification
REQ-027 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> mem_wr_o 4'b1111 once; rdata 0xDEADBEEF at 2-cycle latency.
REQ-028 SB 0x13 data 0x000000A5 -> single access word 4, mem_wr_o 4'b1000, mem_data_o[31:24] = 0xA5; then LB 0x13 -> 0xFFFFFFA5, LBU -> 0x000000A5.
REQ-029 SW 0x1E data 0x11223344 (split) -> word 7 mem_wr_o 4'b1100, then word 8 mem_wr_o 4'b0011; LW 0x1E -> 0x11223344 at 3-cycle latency.
REQ-030 LH at off 0xFFFF (with MEM_BYTES = 65536) -> rsp_err_o = 1, rdata 0, no mem_wr_o activity, 1-cycle latency.
REQ-031 rsp_ready_i held 0 for 5 cycles -> rsp_valid_o and rsp_rdata_o stable, req_ready_o = 0 throughout.
REQ-032 rst_i asserted during ACC1 of a split store -> outputs return to reset values immediately; only the ACC0 word is modified.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, access sizes,
// the captured request bundle and the byte-enable lookup.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC0,
    ACC1,
    RESP
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic        err;
    logic        split;
    logic [15:0] off;
    logic [31:0] wdata;
  } req_t;

  function automatic logic [3:0] size_be(input logic [1:0] size);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SZ_BYTE: be = 4'b0001;
      SZ_HALF: be = 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: shifts the two captured words down to the
// addressed byte, truncates to the access size and extends.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  input  logic [1:0]  shift,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [31:0] win;

  assign win = 32'({hi, lo} >> {shift, 3'b000});

  always_comb begin
    data = win;
    unique case (1'b1)
      size == SZ_BYTE: data = {{24{~uns & win[7]}}, win[7:0]};
      size == SZ_HALF: data = {{16{~uns & win[15]}}, win[15:0]};
      default:         data = win;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit with misaligned accesses split
// across two memory words and bounds checking on the data window.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [31:0] DATA_START_ADDRESS = 32'h00000000,
  parameter int          MEM_BYTES          = 65536
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [13:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [3:0]  mem_wr_o,
  input  logic [31:0] mem_data_i
);

  state_t      state;
  state_t      state_n;
  req_t        req_q;
  logic [31:0] lo_q;
  logic [31:0] hi_q;
  logic [13:0] addr_q;
  logic [31:0] data_q;

  logic [31:0] off;
  logic [3:0]  nbytes;
  logic [32:0] last;
  logic        err;
  logic        split;
  logic [7:0]  be;
  logic [63:0] wd;
  logic [31:0] ld;

  assign off    = req_addr_i - DATA_START_ADDRESS;
  assign nbytes = 4'd1 << req_size_i;
  assign last   = {1'b0, off} + {29'b0, nbytes} - 33'd1;
  assign err    = (req_size_i == SZ_RSVD)
               || (last >= 33'(MEM_BYTES));
  assign split  = ({2'b00, off[1:0]} + nbytes) > 4'd4;

  // Lanes [3:0] go to the first word, [7:4] spill into the next one
  assign be = {4'b0000, size_be(req_q.size)} << req_q.off[1:0];
  assign wd = {32'b0, req_q.wdata} << {req_q.off[1:0], 3'b000};

  lsu_load_align u_align (
    .lo    (lo_q),
    .hi    (hi_q),
    .shift (req_q.off[1:0]),
    .size  (req_q.size),
    .uns   (req_q.uns),
    .data  (ld)
  );

  always_comb begin
    state_n     = state;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    mem_wr_o    = 4'b0000;
    mem_addr_o  = addr_q;
    mem_data_o  = data_q;
    unique case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          state_n = err ? RESP : ACC0;
        end
      end
      ACC0: begin
        mem_addr_o = req_q.off[15:2];
        mem_data_o = wd[31:0];
        if (req_q.we) begin
          mem_wr_o = be[3:0];
        end
        state_n = req_q.split ? ACC1 : RESP;
      end
      ACC1: begin
        mem_addr_o = req_q.off[15:2] + 14'd1;
        mem_data_o = wd[63:32];
        if (req_q.we) begin
          mem_wr_o = be[7:4];
        end
        state_n = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign rsp_err_o   = (state == RESP) && req_q.err;
  assign rsp_rdata_o = ((state == RESP) && !req_q.err && !req_q.we)
                     ? ld : 32'h0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      req_q  <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && req_valid_i) begin
        req_q <= '{
          we:    req_we_i,
          size:  req_size_i,
          uns:   req_unsigned_i,
          err:   err,
          split: split,
          off:   off[15:0],
          wdata: req_wdata_i
        };
      end
      if (state == ACC0) begin
        lo_q <= mem_data_i;
      end
      if (state == ACC1) begin
        hi_q <= mem_data_i;
      end
      if (state == ACC0 || state == ACC1) begin
        addr_q <= mem_addr_o;
        data_q <= mem_data_o;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: byte-level reference memory model, a per-cycle
// compare process, and directed vectors with literal expectations.
module tb_load_store_unit;

  localparam logic [31:0] START = 32'h0;

  typedef struct packed {
    logic [13:0] word;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'd0;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_addr_i = 32'h0;
  logic [31:0] req_wdata_i = 32'h0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [13:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [3:0]  mem_wr_o;
  logic [31:0] mem_data_i;

  always #5 clk = ~clk;

  load_store_unit #(
    .DATA_START_ADDRESS (START),
    .MEM_BYTES          (65536)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_wr_o       (mem_wr_o),
    .mem_data_i     (mem_data_i)
  );

  logic [31:0] mem [16384];
  logic [7:0]  ref_b [65536];

  assign mem_data_i = mem[mem_addr_o];

  always @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (mem_wr_o[l]) mem[mem_addr_o][8*l +: 8] <= mem_data_o[8*l +: 8];
    end
  end

  int          n_total = 0;
  int          n_pass = 0;
  wr_t         exp_wr[$];
  wr_t         obs_wr[$];
  logic [31:0] exp_rdata = 32'h0;
  logic        exp_err = 1'b0;
  wr_t         e_c;
  logic [31:0] m_c;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int l = 0; l < 4; l++) m[8*l +: 8] = {8{be[l]}};
    return m;
  endfunction

  // Compare process: every write and every response cycle
  always @(negedge clk) begin
    if (rst_i) begin
      if (mem_wr_o != 4'b0000) begin
        obs_wr.push_back({mem_addr_o, mem_wr_o, mem_data_o});
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", 32'(mem_wr_o), 32'h0);
        end else begin
          e_c = exp_wr.pop_front();
          m_c = be_mask(e_c.be);
          chk("wr_word", 32'(mem_addr_o), 32'(e_c.word));
          chk("wr_be", 32'(mem_wr_o), 32'(e_c.be));
          chk("wr_data", mem_data_o & m_c, e_c.data & m_c);
        end
      end
      if (rsp_valid_o) begin
        chk("rsp_rdata", rsp_rdata_o, exp_rdata);
        chk("rsp_err", 32'(rsp_err_o), 32'(exp_err));
        chk("ready_while_busy", 32'(req_ready_o), 32'h0);
      end
    end
  end

  // Reference model: byte-addressed memory, spec-level access rules
  task automatic model(input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr,
                       input logic [31:0] wdata, output int lat);
    logic [31:0] off;
    logic [32:0] last;
    logic [31:0] v;
    wr_t         w [2];
    int          n, a, k, nw;
    off = addr - START;
    n = 1 << size;
    last = {1'b0, off} + 33'(n) - 33'd1;
    exp_err = (size == 2'd3) || (last >= 33'd65536);
    exp_rdata = 32'h0;
    lat = 1;
    if (!exp_err) begin
      lat = ((int'(off[1:0]) + n) > 4) ? 3 : 2;
      w[0] = '0;
      w[1] = '0;
      nw = 0;
      v = 32'h0;
      for (int i = 0; i < n; i++) begin
        a = int'(off) + i;
        if (we) begin
          k = (a / 4) - int'(off / 4);
          w[k].word = 14'(a / 4);
          w[k].be[a % 4] = 1'b1;
          w[k].data[8*(a % 4) +: 8] = wdata[8*i +: 8];
          ref_b[a] = wdata[8*i +: 8];
          nw = k + 1;
        end else begin
          v[8*i +: 8] = ref_b[a];
        end
      end
      if (!we && !uns) begin
        if (n == 1 && v[7]) v[31:8] = '1;
        if (n == 2 && v[15]) v[31:16] = '1;
      end
      if (!we) exp_rdata = v;
      for (int j = 0; j < nw; j++) exp_wr.push_back(w[j]);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata, input int stall,
                        output logic [31:0] rd, output logic er,
                        output int lat);
    int exp_lat;
    obs_wr.delete();
    model(we, size, uns, addr, wdata, exp_lat);
    @(negedge clk);
    chk("ready_idle", 32'(req_ready_o), 32'h1);
    req_we_i = we;
    req_size_i = size;
    req_unsigned_i = uns;
    req_addr_i = addr;
    req_wdata_i = wdata;
    req_valid_i = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      // Garbage store held valid while busy must be ignored
      req_we_i = 1'b1;
      req_size_i = 2'd2;
      req_addr_i = 32'h100;
      req_wdata_i = 32'hBADBAD00;
      lat++;
    end while (!rsp_valid_o && lat < 20);
    chk("latency", 32'(lat), 32'(exp_lat));
    rd = rsp_rdata_o;
    er = rsp_err_o;
    repeat (stall) @(negedge clk);
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready_i = 1'b0;
    chk("ready_after_rsp", 32'(req_ready_o), 32'h1);
    chk("valid_after_rsp", 32'(rsp_valid_o), 32'h0);
    chk("pending_writes", 32'(exp_wr.size()), 32'h0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lt;

  initial begin
    for (int b = 0; b < 65536; b++) ref_b[b] = 8'(b) ^ 8'h5A;
    for (int w = 0; w < 16384; w++) begin
      mem[w] = {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
    end

    #12;
    chk("rst_ready", 32'(req_ready_o), 32'h1);
    chk("rst_valid", 32'(rsp_valid_o), 32'h0);
    chk("rst_rdata", rsp_rdata_o, 32'h0);
    chk("rst_err", 32'(rsp_err_o), 32'h0);
    chk("rst_addr", 32'(mem_addr_o), 32'h0);
    chk("rst_data", mem_data_o, 32'h0);
    chk("rst_wr", 32'(mem_wr_o), 32'h0);
    @(negedge clk);
    rst_i = 1'b1;

    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, rd, er, lt);
    chk("sw10_count", 32'(obs_wr.size()), 32'h1);
    chk("sw10_be", 32'(obs_wr[0].be), 32'hF);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, rd, er, lt);
    chk("lw10_lit", rd, 32'hDEADBEEF);
    chk("lw10_lat", 32'(lt), 32'd2);

    do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000A5, 0, rd, er, lt);
    chk("sb13_word", 32'(obs_wr[0].word), 32'd4);
    chk("sb13_be", 32'(obs_wr[0].be), 32'h8);
    chk("sb13_byte", 32'(obs_wr[0].data[31:24]), 32'hA5);
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, rd, er, lt);
    chk("lb13_lit", rd, 32'hFFFFFFA5);
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, rd, er, lt);
    chk("lbu13_lit", rd, 32'h000000A5);

    do_req(1'b1, 2'd2, 1'b0, 32'h1E, 32'h11223344, 0, rd, er, lt);
    chk("sw1e_count", 32'(obs_wr.size()), 32'h2);
    chk("sw1e_w0", {obs_wr[0].word, obs_wr[0].be}, {14'd7, 4'b1100});
    chk("sw1e_w1", {obs_wr[1].word, obs_wr[1].be}, {14'd8, 4'b0011});
    do_req(1'b0, 2'd2, 1'b0, 32'h1E, 32'h0, 0, rd, er, lt);
    chk("lw1e_lit", rd, 32'h11223344);
    chk("lw1e_lat", 32'(lt), 32'd3);

    do_req(1'b0, 2'd1, 1'b0, 32'hFFFF, 32'h0, 0, rd, er, lt);
    chk("lh_ffff_err", 32'(er), 32'h1);
    chk("lh_ffff_rd", rd, 32'h0);
    chk("lh_ffff_lat", 32'(lt), 32'd1);
    chk("lh_ffff_nowr", 32'(obs_wr.size()), 32'h0);

    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, rd, er, lt);
    chk("lw10_stall_lit", rd, 32'hA5ADBEEF);
    do_req(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 0, rd, er, lt);
    chk("lh11_lit", rd, 32'hFFFFADBE);
    do_req(1'b0, 2'd1, 1'b1, 32'h13, 32'h0, 0, rd, er, lt);
    chk("lhu13_lit", rd, 32'h00004EA5);
    do_req(1'b1, 2'd1, 1'b0, 32'hFFFE, 32'h0000BEEF, 0, rd, er, lt);
    chk("sh_fffe_word", 32'(obs_wr[0].word), 32'h3FFF);
    do_req(1'b0, 2'd1, 1'b1, 32'hFFFE, 32'h0, 0, rd, er, lt);
    chk("lhu_fffe_lit", rd, 32'h0000BEEF);
    do_req(1'b0, 2'd0, 1'b0, 32'hFFFF, 32'h0, 0, rd, er, lt);
    chk("lb_ffff_lit", rd, 32'hFFFFFFBE);
    do_req(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 0, rd, er, lt);
    chk("rsvd_err", 32'(er), 32'h1);
    do_req(1'b0, 2'd2, 1'b0, 32'hFFFD, 32'h0, 0, rd, er, lt);
    chk("lw_fffd_err", 32'(er), 32'h1);
    do_req(1'b1, 2'd0, 1'b0, 32'h10000, 32'h77, 2, rd, er, lt);
    chk("sb_oob_err", 32'(er), 32'h1);
    do_req(1'b1, 2'd2, 1'b0, 32'h40, 32'h0BADF00D, 0, rd, er, lt);
    chk("sw_rd_zero", rd, 32'h0);

    // Reset during the second word of a split store
    exp_wr.push_back({14'd11, 4'b1100, 32'hF00D0000});
    ref_b[16'h2E] = 8'h0D;
    ref_b[16'h2F] = 8'hF0;
    @(negedge clk);
    req_we_i = 1'b1;
    req_size_i = 2'd2;
    req_unsigned_i = 1'b0;
    req_addr_i = 32'h2E;
    req_wdata_i = 32'hCAFEF00D;
    req_valid_i = 1'b1;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    @(posedge clk);
    #1 rst_i = 1'b0;
    #1;
    chk("abort_ready", 32'(req_ready_o), 32'h1);
    chk("abort_valid", 32'(rsp_valid_o), 32'h0);
    chk("abort_rdata", rsp_rdata_o, 32'h0);
    chk("abort_err", 32'(rsp_err_o), 32'h0);
    chk("abort_addr", 32'(mem_addr_o), 32'h0);
    chk("abort_data", mem_data_o, 32'h0);
    chk("abort_wr", 32'(mem_wr_o), 32'h0);
    chk("abort_acc0_seen", 32'(exp_wr.size()), 32'h0);
    @(negedge clk);
    rst_i = 1'b1;
    chk("abort_mem12", mem[12], 32'h69686B6A);
    do_req(1'b0, 2'd2, 1'b0, 32'h2C, 32'h0, 0, rd, er, lt);
    chk("abort_lw2c", rd, 32'hF00D7776);
    do_req(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 0, rd, er, lt);
    chk("abort_lw30", rd, 32'h69686B6A);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
